// File: rtl/pipe_pkg.sv
// Shared hazard-unit types: forwarding mux encodings and register-file select.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipe_pkg;

    // Forwarding mux select driven to the E-stage operand muxes
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;

    // Source operands per instruction (rs1, rs2, rs3 for fused FP ops)
    localparam int NUM_SRC = 3;

    // Per-source register file select as carried by FRegRead*
    typedef enum logic {
        RF_INT = 1'b0,
        RF_FP  = 1'b1
    } regFile_e;

    // M stage holds the younger result, so it beats W
    function automatic logic [1:0] fwdSelect(input logic hitM, input logic hitW);
        if (hitM)
            fwdSelect = FWD_M;
        else if (hitW)
            fwdSelect = FWD_W;
        else
            fwdSelect = FWD_REGFILE;
    endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Bundle of pipeline-stage signals exchanged between the datapath and the hazard unit.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls/flushes are carried as plain outputs of the hazard unit.
//
// master: pipeline datapath (drives stage addresses/enables, receives controls)
// slave : hazard unit (pipe_scoreboard)
interface pipe_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    // D stage
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs3D;
    logic [2:0]        FRegReadD;
    logic [2:0]        UseRsD;
    logic              FpuOpD;
    logic [REG_AW-1:0] RdD;
    logic              FRegWriteD;
    // E stage
    logic [REG_AW-1:0] Rs1E, Rs2E, Rs3E;
    logic [2:0]        FRegReadE;
    logic [REG_AW-1:0] RdE;
    logic              RegWriteE;
    logic              ResultSrcE;
    logic              PCJmpE;
    logic              FpuIssueE;
    // M / W stages
    logic [REG_AW-1:0] RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic              FRegWriteM, FRegWriteW;
    // FPU writeback port
    logic              FpuDone;
    logic [REG_AW-1:0] FpuRd;
    // Hazard unit outputs
    logic [1:0]        ForwardAE, ForwardBE, ForwardCE;
    logic              StallF, StallD, FlushD, FlushE;
    logic              FpuBusy;
    logic [PERF_W-1:0] StallCnt, FlushCnt;
    logic              ErrSpurious;

    modport master (
        output Rs1D, Rs2D, Rs3D, FRegReadD, UseRsD, FpuOpD, RdD, FRegWriteD,
               Rs1E, Rs2E, Rs3E, FRegReadE, RdE, RegWriteE, ResultSrcE, PCJmpE, FpuIssueE,
               RdM, RdW, RegWriteM, RegWriteW, FRegWriteM, FRegWriteW, FpuDone, FpuRd,
        input  ForwardAE, ForwardBE, ForwardCE, StallF, StallD, FlushD, FlushE,
               FpuBusy, StallCnt, FlushCnt, ErrSpurious
    );

    modport slave (
        input  Rs1D, Rs2D, Rs3D, FRegReadD, UseRsD, FpuOpD, RdD, FRegWriteD,
               Rs1E, Rs2E, Rs3E, FRegReadE, RdE, RegWriteE, ResultSrcE, PCJmpE, FpuIssueE,
               RdM, RdW, RegWriteM, RegWriteW, FRegWriteM, FRegWriteW, FpuDone, FpuRd,
        output ForwardAE, ForwardBE, ForwardCE, StallF, StallD, FlushD, FlushE,
               FpuBusy, StallCnt, FlushCnt, ErrSpurious
    );

endinterface

// File: rtl/pipe_scoreboard_fp_scoreboard.sv
// Tracks FP destinations in flight in the FPU and flags RAW/WAW/structural hazards in D.
// Latency: set/clear take effect the cycle after issue/done; lookup is combinational.
// Backpressure: sbStall holds the D instruction; fpuBusy when MAX_OUTSTANDING ops are in flight.
//
// Ports: clk/reset; rsD/fRegReadD/useRsD/fpuOpD/rdD/fRegWriteD describe the D instruction;
// rdE/fpuIssueE mark an issue, fpuDone/fpuRd a completion; outputs sbStall, fpuBusy,
// errSpurious (sticky until reset).
module fp_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]  rsD,
    input  logic [NUM_SRC-1:0]              fRegReadD,
    input  logic [NUM_SRC-1:0]              useRsD,
    input  logic                            fpuOpD,
    input  logic [REG_AW-1:0]               rdD,
    input  logic                            fRegWriteD,
    input  logic [REG_AW-1:0]               rdE,
    input  logic                            fpuIssueE,
    input  logic                            fpuDone,
    input  logic [REG_AW-1:0]               fpuRd,
    output logic                            sbStall,
    output logic                            fpuBusy,
    output logic                            errSpurious
);

    localparam int NREG  = 2 ** REG_AW;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [NREG-1:0]  pending;
    logic [CNT_W-1:0] inflight;
    logic             doneValid;
    logic             rawHit;
    logic             wawHit;

    // A completion for a register that is not pending is ignored by the
    // scoreboard and only raises the sticky error flag.
    assign doneValid = fpuDone & pending[fpuRd];

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            inflight    <= '0;
            errSpurious <= 1'b0;
        end else begin
            if (fpuDone && !pending[fpuRd])
                errSpurious <= 1'b1;
            if (doneValid)
                pending[fpuRd] <= 1'b0;
            // Issued after the clear so a same-register issue+done leaves it pending
            if (fpuIssueE)
                pending[rdE] <= 1'b1;

            if (fpuIssueE && !doneValid && inflight != MAX_CNT)
                inflight <= inflight + CNT_W'(1);
            else if (doneValid && !fpuIssueE && inflight != '0)
                inflight <= inflight - CNT_W'(1);
        end
    end

    always_comb begin
        rawHit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (useRsD[i] && regFile_e'(fRegReadD[i]) == RF_FP && pending[rsD[i]])
                rawHit = 1'b1;
        end
    end

    assign wawHit  = fRegWriteD & pending[rdD];
    assign fpuBusy = (inflight == MAX_CNT);
    assign sbStall = rawHit | wawHit | (fpuOpD & fpuBusy);

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard unit: int/FP forwarding, load-use and FPU-scoreboard stalls, branch flushes, perf counters.
// Latency: controls and forwarding selects are combinational; counters update at the next edge.
// Backpressure: StallF/StallD hold F/D and FlushE bubbles E; a taken branch overrides any stall.
//
// Ports: clk, reset (sync, active high); hz (slave modport of pipe_scoreboard_if) carries the
// D/E/M/W stage addresses and enables, the FPU issue/done port, and all hazard outputs.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PERF_W          = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_scoreboard_if.slave   hz
);

    logic [NUM_SRC-1:0][REG_AW-1:0] rsD;
    logic [NUM_SRC-1:0][REG_AW-1:0] rsE;
    logic [NUM_SRC-1:0][1:0]        fwdSel;
    logic                           loadFp;
    logic                           lwStall;
    logic                           sbStall;
    logic                           stall;
    logic                           stallD;
    logic                           fpuBusy;
    logic                           errSpurious;
    logic [PERF_W-1:0]              stallCnt;
    logic [PERF_W-1:0]              flushCnt;

    assign rsD = {hz.Rs3D, hz.Rs2D, hz.Rs1D};
    assign rsE = {hz.Rs3E, hz.Rs2E, hz.Rs1E};

    // A later stage write matches a source when addresses agree and that stage
    // writes the same file; integer x0 is hardwired so it never forwards.
    function automatic logic wrHit(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd,
        input logic              isFp,
        input logic              intWe,
        input logic              fpWe
    );
        if (rs != rd)
            wrHit = 1'b0;
        else if (isFp)
            wrHit = fpWe;
        else
            wrHit = intWe & (rd != '0);
    endfunction

    always_comb begin
        fwdSel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwdSel[i] = fwdSelect(
                wrHit(rsE[i], hz.RdM, regFile_e'(hz.FRegReadE[i]) == RF_FP, hz.RegWriteM, hz.FRegWriteM),
                wrHit(rsE[i], hz.RdW, regFile_e'(hz.FRegReadE[i]) == RF_FP, hz.RegWriteW, hz.FRegWriteW));
        end
    end

    assign hz.ForwardAE = fwdSel[0];
    assign hz.ForwardBE = fwdSel[1];
    assign hz.ForwardCE = fwdSel[2];

    // A load without an integer write enable targets the FP file
    assign loadFp = ~hz.RegWriteE;

    always_comb begin
        lwStall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.ResultSrcE && hz.UseRsD[i] && rsD[i] == hz.RdE &&
                hz.FRegReadD[i] == loadFp && (loadFp || hz.RdE != '0))
                lwStall = 1'b1;
        end
    end

    fp_scoreboard #(
        .REG_AW          (REG_AW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_fp_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .rsD         (rsD),
        .fRegReadD   (hz.FRegReadD),
        .useRsD      (hz.UseRsD),
        .fpuOpD      (hz.FpuOpD),
        .rdD         (hz.RdD),
        .fRegWriteD  (hz.FRegWriteD),
        .rdE         (hz.RdE),
        .fpuIssueE   (hz.FpuIssueE),
        .fpuDone     (hz.FpuDone),
        .fpuRd       (hz.FpuRd),
        .sbStall     (sbStall),
        .fpuBusy     (fpuBusy),
        .errSpurious (errSpurious)
    );

    // The branch squashes the stalled D instruction anyway, so it wins over stall
    assign stall  = lwStall | sbStall;
    assign stallD = stall & ~hz.PCJmpE;

    assign hz.StallF      = stallD;
    assign hz.StallD      = stallD;
    assign hz.FlushD      = hz.PCJmpE;
    assign hz.FlushE      = stall | hz.PCJmpE;
    assign hz.FpuBusy     = fpuBusy;
    assign hz.ErrSpurious = errSpurious;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallD && stallCnt != '1)
                stallCnt <= stallCnt + PERF_W'(1);
            if (hz.PCJmpE && flushCnt != '1)
                flushCnt <= flushCnt + PERF_W'(1);
        end
    end

    assign hz.StallCnt = stallCnt;
    assign hz.FlushCnt = flushCnt;

endmodule
